lb_sequencer: RTL and testbench

Run-level controller for the line-buffer `memory_core`. It accepts a start command with a depth and a stream length, then latches and holds the memory core's depth configuration. It flushes the core, gates its clock enable for output backpressure, meters producer writes, and inserts zero-data drain writes until every expected output word has left. It sits between the streaming producer/consumer and the memory core, replacing free-running testbench drive of `wen_in`, `flush` and `clk_en`.

---
 rtl/lb_sequencer.sv | 169 ++++++++++++++++
 tb/tb_lb_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lb_sequencer.sv
// Run-level controller for the line-buffer memory core: flush, fill/stream metering, zero-data drain.
// Optional DRAIN watchdog is compiled in with `define LB_SEQ_WATCHDOG_EN.
module lb_sequencer #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [15:0]       cfg_depth,
    input  logic [CNT_W-1:0]  cfg_len,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_wen,
    output logic              mem_flush,
    output logic              mem_clk_en,
    output logic [15:0]       mem_depth,
    input  logic [DATA_W-1:0] mem_data_out,
    input  logic              mem_valid_out,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_FILL,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [15:0]      depth_q;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] in_cnt;
    logic [CNT_W-1:0] out_cnt;
    logic             done_q;
    logic             err_q;

    logic streaming;
    logic draining;
    logic in_take;
    logic out_take;
    logic start_ok;
    logic start_bad;
    logic last_in;
    logic fill_full;
    logic last_out;
    logic wd_trip;

    // Backpressure: a stalled valid output freezes the core and everything feeding it.
    always_comb begin
        streaming   = (state == S_FILL) || (state == S_STREAM);
        draining    = (state == S_DRAIN);
        out_valid   = (streaming || draining) && mem_valid_out;
        mem_clk_en  = !(out_valid && !out_ready);
        in_ready    = streaming && mem_clk_en;
        in_take     = in_valid && in_ready;
        out_take    = out_valid && out_ready;
        mem_wen     = 1'b0;
        mem_data_in = '0;
        if (streaming) begin
            mem_wen     = in_take;
            mem_data_in = in_data;
        end else if (draining) begin
            mem_wen = mem_clk_en;
        end
        mem_flush = (state == S_FLUSH);
        busy      = (state != S_IDLE);
        out_data  = mem_data_out;
        mem_depth = depth_q;
        done      = done_q;
        err       = err_q;
        start_ok  = (state == S_IDLE) && start && (cfg_depth != 16'd0) && (cfg_len != '0);
        start_bad = (state == S_IDLE) && start && !((cfg_depth != 16'd0) && (cfg_len != '0));
        last_in   = in_take && (in_cnt == len_q - CNT_W'(1));
        fill_full = in_take && (in_cnt + CNT_W'(1) == CNT_W'(depth_q));
        last_out  = draining && out_take && (out_cnt == len_q - CNT_W'(1));
    end

`ifdef LB_SEQ_WATCHDOG_EN
    logic [19:0] wd_cnt;
    logic [19:0] wd_limit;

    // Held at zero outside DRAIN, so entering DRAIN always starts a fresh count.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt <= '0;
        end else if (!draining || mem_valid_out) begin
            wd_cnt <= '0;
        end else if (mem_clk_en) begin
            wd_cnt <= wd_cnt + 20'd1;
        end
    end

    always_comb begin
        wd_limit = {2'b00, depth_q, 2'b00};
        wd_trip  = draining && mem_clk_en && !mem_valid_out && (wd_cnt + 20'd1 == wd_limit);
    end
`else
    assign wd_trip = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The last input word wins over the FILL->STREAM step, so short runs skip STREAM.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start_ok) state_nxt = S_FLUSH;
            S_FLUSH:  state_nxt = S_FILL;
            S_FILL: begin
                if (last_in) begin
                    state_nxt = S_DRAIN;
                end else if (fill_full) begin
                    state_nxt = S_STREAM;
                end
            end
            S_STREAM: if (last_in) state_nxt = S_DRAIN;
            S_DRAIN: begin
                if (last_out) begin
                    state_nxt = S_DONE;
                end else if (wd_trip) begin
                    state_nxt = S_IDLE;
                end
            end
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            depth_q <= '0;
            len_q   <= '0;
            in_cnt  <= '0;
            out_cnt <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= last_out;
            err_q  <= start_bad || wd_trip;
            if (start_ok) begin
                depth_q <= cfg_depth;
                len_q   <= cfg_len;
                in_cnt  <= '0;
                out_cnt <= '0;
            end else begin
                if (in_take) in_cnt <= in_cnt + CNT_W'(1);
                if (out_take) out_cnt <= out_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_lb_sequencer.sv
// Self-checking bench for lb_sequencer: line-buffer core model, per-cycle scoreboard, directed runs.
// Define LB_SEQ_WATCHDOG_EN to also exercise the DRAIN watchdog.
module tb_lb_sequencer;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 17;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [15:0]       cfg_depth = '0;
    logic [CNT_W-1:0]  cfg_len = '0;
    logic [DATA_W-1:0] in_data = 16'h0101;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_wen;
    logic              mem_flush;
    logic              mem_clk_en;
    logic [15:0]       mem_depth;
    logic [DATA_W-1:0] mem_data_out;
    logic              mem_valid_out;
    logic              busy;
    logic              done;
    logic              err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lb_sequencer #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .cfg_depth    (cfg_depth),
        .cfg_len      (cfg_len),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .mem_data_in  (mem_data_in),
        .mem_wen      (mem_wen),
        .mem_flush    (mem_flush),
        .mem_clk_en   (mem_clk_en),
        .mem_depth    (mem_depth),
        .mem_data_out (mem_data_out),
        .mem_valid_out(mem_valid_out),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    // Line-buffer core: after write k it presents word k-depth; it freezes when clk_en is low.
    logic [DATA_W-1:0] hist [0:255];
    int                core_n = 0;
    logic              core_mute = 1'b0;

    always @(posedge clk) begin
        if (reset || mem_flush) begin
            core_n <= 0;
        end else if (mem_clk_en && mem_wen) begin
            hist[core_n[7:0]] <= mem_data_in;
            core_n <= core_n + 1;
        end
    end

    always_comb begin
        int idx;
        idx           = 0;
        mem_valid_out = 1'b0;
        mem_data_out  = '0;
        if (!core_mute && core_n > int'(mem_depth)) begin
            idx           = core_n - 1 - int'(mem_depth);
            mem_valid_out = 1'b1;
            mem_data_out  = hist[idx[7:0]];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard state shared by the monitor and the directed tasks.
    logic [DATA_W-1:0] exp_q[$];
    logic [15:0]       exp_depth = '0;
    logic [CNT_W-1:0]  exp_len = '0;
    int cyc = 0, acc_cnt = 0, hs_cnt = 0, flush_cnt = 0, done_cnt = 0, err_cnt = 0;
    int stall_cnt = 0, dummy_cnt = 0, last_hs_cyc = -10;
    logic took = 1'b0;

    always @(posedge clk) begin
        #1;
        if (took) in_data = in_data + 16'h1111;
    end

    always @(negedge clk) begin
        cyc++;
        took = 1'b0;
        if (reset) begin
            exp_q.delete();
        end else begin
            checkOutput("mem_depth", 32'(mem_depth), 32'(exp_depth));
            checkOutput("clk_en_rule", 32'(mem_clk_en), 32'(!(out_valid && !out_ready)));
            checkOutput("out_data_pass", 32'(out_data), 32'(mem_data_out));
            if (in_ready) begin
                checkOutput("in_ready_needs_clk_en", 32'(mem_clk_en), 1);
                checkOutput("wen_on_ready", 32'(mem_wen), 32'(in_valid));
            end
            if (in_valid && in_ready) begin
                checkOutput("write_data", 32'(mem_data_in), 32'(in_data));
                checkOutput("accept_bound", 32'(acc_cnt < int'(exp_len)), 1);
                exp_q.push_back(in_data);
                acc_cnt++;
                took = 1'b1;
            end
            if (busy && !in_ready && mem_wen) begin
                checkOutput("dummy_zero", 32'(mem_data_in), 0);
                dummy_cnt++;
            end
            if (mem_flush) begin
                checkOutput("flush_no_wen", 32'(mem_wen), 0);
                flush_cnt++;
            end
            if (busy && !mem_clk_en && !in_ready) stall_cnt++;
            if (out_valid && out_ready) begin
                checkOutput("out_underflow", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) checkOutput("out_word", 32'(out_data), 32'(exp_q.pop_front()));
                hs_cnt++;
                last_hs_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                checkOutput("done_timing", cyc, last_hs_cyc + 1);
                checkOutput("done_hs_count", hs_cnt, 32'(exp_len));
            end
            if (err) err_cnt++;
        end
    end

    task automatic clearStats();
        acc_cnt = 0; hs_cnt = 0; flush_cnt = 0; done_cnt = 0;
        err_cnt = 0; stall_cnt = 0; dummy_cnt = 0;
        exp_q.delete();
    endtask

    task automatic doStart(input logic [15:0] d, input logic [CNT_W-1:0] l);
        @(posedge clk); #1;
        start = 1'b1; cfg_depth = d; cfg_len = l;
        @(posedge clk); #1;
        start = 1'b0;
        if (d != 16'd0 && l != '0) begin
            exp_depth = d;
            exp_len   = l;
        end
    endtask

    task automatic waitOutValid(input string name);
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, 32'(out_valid), 1);
    endtask

    task automatic applyStimulus(input logic [15:0] d, input logic [CNT_W-1:0] l,
                                 input bit stall, input int exp_dummy);
        int n;
        clearStats();
        in_valid = 1'b1;
        out_ready = 1'b1;
        doStart(d, l);
        @(negedge clk);
        checkOutput("flush_pulse", 32'(mem_flush), 1);
        checkOutput("flush_in_ready", 32'(in_ready), 0);
        checkOutput("flush_busy", 32'(busy), 1);
        @(negedge clk);
        checkOutput("first_in_ready", 32'(in_ready), 1);
        if (stall) begin
            waitOutValid("stall_reach");
            @(posedge clk); #1;
            out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            out_ready = 1'b1;
        end
        n = 0;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput("done_seen", 32'(done), 1);
        @(negedge clk);
        checkOutput("busy_after_done", 32'(busy), 0);
        checkOutput("accepted_total", acc_cnt, 32'(l));
        checkOutput("handshake_total", hs_cnt, 32'(l));
        checkOutput("flush_total", flush_cnt, 1);
        checkOutput("done_total", done_cnt, 1);
        checkOutput("err_total", err_cnt, 0);
        checkOutput("queue_empty", exp_q.size(), 0);
        checkOutput("dummy_total", dummy_cnt, exp_dummy);
        checkOutput("stall_total", stall_cnt, stall ? 3 : 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic rejectStart(input logic [15:0] d, input logic [CNT_W-1:0] l);
        clearStats();
        doStart(d, l);
        @(negedge clk);
        checkOutput("reject_err", 32'(err), 1);
        checkOutput("reject_busy", 32'(busy), 0);
        checkOutput("reject_flush", 32'(mem_flush), 0);
        @(negedge clk);
        checkOutput("reject_err_clear", 32'(err), 0);
        checkOutput("reject_err_total", err_cnt, 1);
        checkOutput("reject_flush_total", flush_cnt, 0);
    endtask

    task automatic resetMidStream();
        clearStats();
        in_valid = 1'b1;
        out_ready = 1'b1;
        doStart(16'd4, 17'd8);
        waitOutValid("reset_reach_stream");
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        in_valid = 1'b0;
        exp_depth = '0;
        exp_len = '0;
        @(negedge clk);
        checkOutput("reset_idle", 32'(busy), 0);
        checkOutput("reset_depth", 32'(mem_depth), 0);
        repeat (10) @(negedge clk);
        checkOutput("reset_no_done", done_cnt, 0);
        checkOutput("reset_no_err", err_cnt, 0);
    endtask

`ifdef LB_SEQ_WATCHDOG_EN
    task automatic watchdogRun();
        int n;
        clearStats();
        core_mute = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        doStart(16'd4, 17'd2);
        n = 0;
        while (!err && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("wd_err", 32'(err), 1);
        checkOutput("wd_idle", 32'(busy), 0);
        checkOutput("wd_drain_cycles", dummy_cnt, 16);
        checkOutput("wd_no_done", done_cnt, 0);
        checkOutput("wd_accepted", acc_cnt, 2);
        @(posedge clk); #1;
        in_valid = 1'b0;
        core_mute = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout actual=running expected=finished");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("rst_in_ready", 32'(in_ready), 0);
            checkOutput("rst_out_valid", 32'(out_valid), 0);
            checkOutput("rst_mem_wen", 32'(mem_wen), 0);
            checkOutput("rst_mem_flush", 32'(mem_flush), 0);
            checkOutput("rst_mem_clk_en", 32'(mem_clk_en), 1);
            checkOutput("rst_busy", 32'(busy), 0);
            checkOutput("rst_done", 32'(done), 0);
            checkOutput("rst_err", 32'(err), 0);
            checkOutput("rst_mem_depth", 32'(mem_depth), 0);
        end
        $display("[TB] run depth=4 len=8");
        applyStimulus(16'd4, 17'd8, 1'b0, 5);
        $display("[TB] run depth=4 len=8 with consumer stall");
        applyStimulus(16'd4, 17'd8, 1'b1, 5);
        $display("[TB] rejected starts");
        rejectStart(16'd0, 17'd8);
        rejectStart(16'd4, 17'd0);
        $display("[TB] run depth=8 len=3");
        applyStimulus(16'd8, 17'd3, 1'b0, 9);
        $display("[TB] reset during stream");
        resetMidStream();
`ifdef LB_SEQ_WATCHDOG_EN
        $display("[TB] watchdog run");
        watchdogRun();
`endif
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
